// File: rtl/reg_writeback_buffer_if.sv
// Execute-stage request, stack write port and forwarding bundle of the register write-back buffer.
// The master drives requests, Hold and forwarding addresses. The slave (the buffer) drives the rest.
interface reg_writeback_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              hold;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              write_reg;

  logic [ADDR_W-1:0] fwd_addr_a;
  logic              fwd_hit_a;
  logic [DATA_W-1:0] fwd_data_a;
  logic [ADDR_W-1:0] fwd_addr_b;
  logic              fwd_hit_b;
  logic [DATA_W-1:0] fwd_data_b;

  logic [CNT_W-1:0]  count;
  logic              empty;

  modport master (
    output in_valid, in_addr, in_data, hold, fwd_addr_a, fwd_addr_b,
    input  in_ready, w_addr, w_data, write_reg,
    input  fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b, count, empty
  );

  modport slave (
    input  in_valid, in_addr, in_data, hold, fwd_addr_a, fwd_addr_b,
    output in_ready, w_addr, w_data, write_reg,
    output fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b, count, empty
  );
endinterface

// File: rtl/reg_writeback_buffer.sv
// Queues write-back requests and issues one register write per cycle; a push reaches Write_Reg one edge later.
// In_Ready drops only when the queue is full, even on a popping cycle. Hold stalls issue, never pushes.
module reg_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  reg_writeback_buffer_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              write_reg_q, write_reg_d;

  logic in_ready;
  logic push;
  logic pop;

  assign in_ready = (count_q < CNT_W'(DEPTH));
  // Address 0 is accepted for handshake purposes but never occupies an entry.
  assign push     = bus.in_valid & in_ready & (bus.in_addr != '0);
  assign pop      = ~bus.hold & (count_q != '0);

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    write_reg_d = 1'b0;
    if (pop) begin
      w_addr_d    = mem_addr_q[head_q];
      w_data_d    = mem_data_q[head_q];
      write_reg_d = 1'b1;
      head_d      = head_q + PTR_W'(1);
    end
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      write_reg_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      write_reg_q <= write_reg_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_addr_q[tail_q] <= bus.in_addr;
      mem_data_q[tail_q] <= bus.in_data;
    end
  end

  // Scan oldest to youngest (output stage, then queue from head) so the last match wins.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] addr);
    logic              hit;
    logic [DATA_W-1:0] dat;
    logic [PTR_W-1:0]  idx;
    hit = 1'b0;
    dat = '0;
    idx = '0;
    if (addr != '0) begin
      if (write_reg_q && (w_addr_q == addr)) begin
        hit = 1'b1;
        dat = w_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (mem_addr_q[idx] == addr)) begin
          hit = 1'b1;
          dat = mem_data_q[idx];
        end
      end
    end
    return {hit, dat};
  endfunction

  always_comb begin
    {bus.fwd_hit_a, bus.fwd_data_a} = fwd_lookup(bus.fwd_addr_a);
  end

  always_comb begin
    {bus.fwd_hit_b, bus.fwd_data_b} = fwd_lookup(bus.fwd_addr_b);
  end

  assign bus.in_ready  = in_ready;
  assign bus.w_addr    = w_addr_q;
  assign bus.w_data    = w_data_q;
  assign bus.write_reg = write_reg_q;
  assign bus.count     = count_q;
  assign bus.empty     = (count_q == '0) & ~write_reg_q;

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// Bench for reg_writeback_buffer: queue model feeds a scoreboard of expected writes, a monitor pops it per Write_Reg pulse.
module tb_reg_writeback_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ent_t mq[$];    // model of queued entries
  ent_t sb_q[$];  // expected writes in issue order
  logic m_wr = 1'b0;

  reg_writeback_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reg_writeback_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pre-edge occupancy decides acceptance; a pop becomes an expected write.
  initial begin
    ent_t e;
    logic rdy;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        sb_q.delete();
        m_wr = 1'b0;
      end else begin
        rdy  = (mq.size() < DEPTH);
        m_wr = 1'b0;
        if (!bus.hold && mq.size() > 0) begin
          e = mq.pop_front();
          sb_q.push_back(e);
          m_wr = 1'b1;
        end
        if (bus.in_valid && rdy && bus.in_addr != '0) begin
          e.a = bus.in_addr;
          e.d = bus.in_data;
          mq.push_back(e);
        end
      end
    end
  end

  // Monitor: every write pulse must match the oldest expected write.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("mon_write_reg", {31'd0, bus.write_reg}, {31'd0, m_wr});
        chk("mon_count", {29'd0, bus.count}, mq.size());
        chk("mon_in_ready", {31'd0, bus.in_ready}, {31'd0, (mq.size() < DEPTH)});
        if (bus.write_reg) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL mon_unexpected_write: got addr 0x%0h data 0x%0h, expected no write", bus.w_addr, bus.w_data);
          end else begin
            e = sb_q.pop_front();
            chk("mon_w_addr", {27'd0, bus.w_addr}, {27'd0, e.a});
            chk("mon_w_data", bus.w_data, e.d);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_addr    = '0;
    bus.in_data    = '0;
    bus.hold       = 1'b0;
    bus.fwd_addr_a = '0;
    bus.fwd_addr_b = '0;
    #12 rst = 1'b0;

    // 1: reset state and single-write latency
    @(negedge clk);
    chk("rst_count", {29'd0, bus.count}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_write_reg", {31'd0, bus.write_reg}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_w_addr", {27'd0, bus.w_addr}, 32'd0);
    chk("rst_w_data", bus.w_data, 32'd0);
    bus.in_valid = 1'b1; bus.in_addr = 5'd3; bus.in_data = 32'hAAAA_0001;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t1_count_after_push", {29'd0, bus.count}, 32'd1);
    chk("t1_no_write_yet", {31'd0, bus.write_reg}, 32'd0);
    @(negedge clk);
    chk("t1_write_reg", {31'd0, bus.write_reg}, 32'd1);
    chk("t1_w_addr", {27'd0, bus.w_addr}, 32'd3);
    chk("t1_w_data", bus.w_data, 32'hAAAA_0001);
    @(negedge clk);
    chk("t1_empty", {31'd0, bus.empty}, 32'd1);

    // 2: fill under Hold, refuse fifth push, drain in order
    bus.hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1; bus.in_addr = 5'(i); bus.in_data = 32'h100 + i;
      @(negedge clk);
    end
    bus.in_addr = 5'd7; bus.in_data = 32'hDEAD_BEEF;
    chk("t2_full_count", {29'd0, bus.count}, 32'd4);
    chk("t2_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t2_fifth_ignored", {29'd0, bus.count}, 32'd4);
    bus.hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t2_issue_pulse", {31'd0, bus.write_reg}, 32'd1);
      chk("t2_issue_addr", {27'd0, bus.w_addr}, 32'(i));
      chk("t2_issue_data", bus.w_data, 32'h100 + i);
    end
    @(negedge clk);
    chk("t2_drained", {31'd0, bus.empty}, 32'd1);

    // 3: forwarding of the youngest matching entry
    bus.hold = 1'b1; bus.fwd_addr_a = 5'd5; bus.fwd_addr_b = 5'd9;
    bus.in_valid = 1'b1; bus.in_addr = 5'd5; bus.in_data = 32'h11;
    @(negedge clk);
    chk("t3_fwd_one_entry", bus.fwd_data_a, 32'h11);
    bus.in_data = 32'h22;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("t3_hit_a", {31'd0, bus.fwd_hit_a}, 32'd1);
    chk("t3_data_a", bus.fwd_data_a, 32'h22);
    chk("t3_hit_b_other_addr", {31'd0, bus.fwd_hit_b}, 32'd0);
    chk("t3_data_b_other_addr", bus.fwd_data_b, 32'd0);
    bus.hold = 1'b0;
    @(negedge clk);
    chk("t3_hit_after_first_issue", {31'd0, bus.fwd_hit_a}, 32'd1);
    chk("t3_data_queue_younger", bus.fwd_data_a, 32'h22);
    @(negedge clk);
    chk("t3_second_write", bus.w_data, 32'h22);
    chk("t3_hit_output_stage", {31'd0, bus.fwd_hit_a}, 32'd1);
    chk("t3_data_output_stage", bus.fwd_data_a, 32'h22);
    @(negedge clk);
    chk("t3_hit_cleared", {31'd0, bus.fwd_hit_a}, 32'd0);
    chk("t3_data_cleared", bus.fwd_data_a, 32'd0);

    // 4: address 0 is accepted but dropped, and never forwards
    bus.fwd_addr_b = 5'd0;
    bus.in_valid = 1'b1; bus.in_addr = 5'd0; bus.in_data = 32'hFFFF;
    #1;
    chk("t4_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t4_count", {29'd0, bus.count}, 32'd0);
    chk("t4_empty", {31'd0, bus.empty}, 32'd1);
    chk("t4_hit_b_zero", {31'd0, bus.fwd_hit_b}, 32'd0);
    @(negedge clk);
    chk("t4_no_write", {31'd0, bus.write_reg}, 32'd0);

    // 5: sustained traffic against a full queue, pointer wrap
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_addr = 5'(8 + i); bus.in_data = 32'h4000 + i;
      @(negedge clk);
    end
    bus.hold = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.in_valid = 1'b1; bus.in_addr = 5'(12 + k); bus.in_data = 32'h5000 + k;
      @(negedge clk);
      chk("t5_count_bound", {31'd0, (bus.count <= 3'(DEPTH))}, 32'd1);
    end
    bus.in_valid = 1'b0;
    for (int n = 0; n < 20 && !(bus.empty === 1'b1); n++) @(negedge clk);
    chk("t5_drain_empty", {31'd0, bus.empty}, 32'd1);

    // 6: reset while a write is in flight discards everything
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_addr = 5'(20 + i); bus.in_data = 32'h6000 + i;
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.hold = 1'b0;
    @(negedge clk);
    chk("t6_pre_count", {29'd0, bus.count}, 32'd3);
    chk("t6_pre_write_reg", {31'd0, bus.write_reg}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_write_reg", {31'd0, bus.write_reg}, 32'd0);
    chk("t6_rst_count", {29'd0, bus.count}, 32'd0);
    chk("t6_rst_empty", {31'd0, bus.empty}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t6_no_write_after_rst", {31'd0, bus.write_reg}, 32'd0);
    end

    chk("final_scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
